fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter: TAG_W, default 4, width of the requester tag echoed with each response.
REQ-002 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  out  2  per-requester request accept.
REQ-007 req_a  in  64  operand A, {req1_a, req0_a}, IEEE-754 single.
REQ-008 req_b  in  64  operand B, {req1_b, req0_b}.
REQ-009 req_rmode  in  6  rounding mode, {req1_rmode, req0_rmode}; 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-010 req_tag  in  2*TAG_W  per-requester tag, {req1_tag, req0_tag}.
REQ-011 rsp_valid  out  2  per-requester response valid.
REQ-012 rsp_ready  in  2  per-requester response accept.
REQ-013 rsp_result  out  32  sum, shared by both response ports; qualified by rsp_valid.
REQ-014 rsp_flags  out  2  {overflow, underflow} of the result.
REQ-015 rsp_tag  out  TAG_W  tag of the operation being returned.
REQ-016 add_a, add_b  out  32 each  operands driven to the shared combinational fp adder.
REQ-017 add_rmode  out  3  rounding mode driven to the shared adder.
REQ-018 add_result  in  32; add_overflow, add_underflow  in  1 each  shared adder outputs.
REQ-019 busy  out  1  high whenever state is not IDLE.
REQ-020 done_count  out  CNT_W  completed responses since reset.

Function
REQ-021 FSM SHALL have states IDLE, EXEC, RESP.
REQ-022 In IDLE, grant g SHALL be: the only valid requester if one; if both valid, requester ~last_grant; req_ready[g]=1 combinationally, other bit 0.
REQ-023 req_ready SHALL be 2'b00 in EXEC and RESP and in IDLE with no valid request.
REQ-024 On IDLE accept (req_valid[g] & req_ready[g]): register a, b, rmode, tag of g, store g, set last_grant=g, go EXEC.
REQ-025 Accepted rmode 101..111 SHALL be coerced to 000 before registration.
REQ-026 add_a/add_b/add_rmode SHALL be driven from operand registers in EXEC and RESP; 0 in IDLE.
REQ-027 In EXEC (exactly one cycle): capture add_result, add_overflow, add_underflow into response registers, go RESP.
REQ-028 In RESP: rsp_valid[g]=1, other bit 0; result/flags/tag held stable until handshake.
REQ-029 On rsp_valid[g] & rsp_ready[g]: go IDLE, done_count += 1 (wraps 2^CNT_W-1 -> 0).
REQ-030 rsp_ready on the non-granted bit SHALL be ignored.
REQ-031 Latency: accept at cycle N -> rsp_valid at N+2; next accept no earlier than the cycle after response handshake (min 3 cycles/op).
REQ-032 New requests arriving in EXEC/RESP SHALL wait (not dropped); requesters hold valid and payload until accepted.
REQ-033 No requester SHALL wait more than one other operation while continuously valid (starvation-free).

Reset
REQ-034 When rst_n=0 at a clock edge: state IDLE, last_grant=1 (requester 0 wins first tie), done_count=0, operand/response registers 0.
REQ-035 Outputs during/after reset: req_ready depends only on req_valid per REQ-022, rsp_valid=0, busy=0, add_*=0, rsp_result=0, rsp_flags=0, rsp_tag=0.
REQ-036 Reset mid-operation (EXEC or RESP) SHALL discard the pending operation; no response issued for it.

Verification
REQ-037 Single op: req0 a=3F800000, b=3F800000, rmode 000, tag 5, rsp_ready=1 -> add_a/add_b=3F800000 at N+1, rsp_valid[0] at N+2, result=40000000, tag 5, done_count 1.
REQ-038 Tie after reset: both valid same cycle -> req0 granted first, req1 granted on next IDLE; then both valid again -> req0 granted (alternation).
REQ-039 Backpressure: rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid, result, tag stable, req_ready=00, busy=1 throughout; handshake on cycle 6 -> IDLE.
REQ-040 rmode 111 on req1 -> add_rmode=000 in EXEC.
REQ-041 rst_n=0 during RESP -> next cycle rsp_valid=00, busy=0, done_count=0; no response for discarded op.
REQ-042 Counter wrap with CNT_W=2: 4 completed ops -> done_count 3 -> 0.

Source files
------------

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_add_arbiter
//  Purpose  : Two-requester front end for one shared combinational IEEE-754
//             single-precision adder. It grants one request at a time,
//             alternating on ties, and holds the operands on the adder for
//             one cycle. It then returns the registered sum with its tag on
//             the granted response port. One operation is in flight at a time.
//  Ports    : clk, rst_n (sync, active-low)
//             req_valid/req_ready[1:0], req_a/req_b[63:0], req_rmode[5:0],
//             req_tag[2*TAG_W-1:0]            -- packed {req1, req0} requests
//             rsp_valid/rsp_ready[1:0], rsp_result[31:0], rsp_flags[1:0],
//             rsp_tag[TAG_W-1:0]              -- shared response payload
//             add_a/add_b[31:0], add_rmode[2:0] -> shared adder inputs
//             add_result[31:0], add_overflow, add_underflow <- adder outputs
//             busy, done_count[CNT_W-1:0]     -- status
//  Revision : 1.0  initial release
// ============================================================================
module fp_add_arbiter #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [63:0]        req_a,
   input  logic [63:0]        req_b,
   input  logic [5:0]         req_rmode,
   input  logic [2*TAG_W-1:0] req_tag,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [31:0]        rsp_result,
   output logic [1:0]         rsp_flags,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic [31:0]        add_a,
   output logic [31:0]        add_b,
   output logic [2:0]         add_rmode,
   input  logic [31:0]        add_result,
   input  logic               add_overflow,
   input  logic               add_underflow,
   output logic               busy,
   output logic [CNT_W-1:0]   done_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               gnt_sel;      // requester chosen this cycle (IDLE only)
   logic               gnt_q;        // requester owning the in-flight op
   logic               last_grant;
   logic               accept;
   logic               rsp_hs;
   logic [31:0]        sel_a, sel_b;
   logic [2:0]         sel_rmode;
   logic [TAG_W-1:0]   sel_tag;
   logic [31:0]        op_a, op_b;
   logic [2:0]         op_rmode;
   logic [TAG_W-1:0]   op_tag;
   logic [31:0]        res_q;
   logic [1:0]         flags_q;

   // A lone requester always wins; a tie goes to whoever was not served last.
   always_comb begin
      gnt_sel = ~last_grant;
      if (req_valid == 2'b01)
         gnt_sel = 1'b0;
      else if (req_valid == 2'b10)
         gnt_sel = 1'b1;
   end

   always_comb begin
      sel_a     = gnt_sel ? req_a[63:32]           : req_a[31:0];
      sel_b     = gnt_sel ? req_b[63:32]           : req_b[31:0];
      sel_rmode = gnt_sel ? req_rmode[5:3]         : req_rmode[2:0];
      sel_tag   = gnt_sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
   end

   // FSM: next state and all handshake outputs
   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               req_ready = gnt_sel ? 2'b10 : 2'b01;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid = gnt_q ? 2'b10 : 2'b01;
            // Only the granted port's ready counts; the other bit is masked
            // by rsp_valid.
            if (|(rsp_ready & (gnt_q ? 2'b10 : 2'b01)))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = |(req_valid & req_ready);
   assign rsp_hs = |(rsp_valid & rsp_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt_q      <= 1'b0;
         last_grant <= 1'b1;          // requester 0 wins the first tie
         op_a       <= '0;
         op_b       <= '0;
         op_rmode   <= '0;
         op_tag     <= '0;
         res_q      <= '0;
         flags_q    <= '0;
         done_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && accept) begin
            gnt_q      <= gnt_sel;
            last_grant <= gnt_sel;
            op_a       <= sel_a;
            op_b       <= sel_b;
            // Encodings above RMM are reserved; fall back to RNE.
            op_rmode   <= (sel_rmode > 3'd4) ? 3'd0 : sel_rmode;
            op_tag     <= sel_tag;
         end
         if (state == EXEC) begin
            res_q   <= add_result;
            flags_q <= {add_overflow, add_underflow};
         end
         if (rsp_hs)
            done_count <= done_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // The adder sees operands only while an operation is in flight.
   assign add_a      = (state == IDLE) ? 32'd0 : op_a;
   assign add_b      = (state == IDLE) ? 32'd0 : op_b;
   assign add_rmode  = (state == IDLE) ? 3'd0  : op_rmode;
   assign busy       = (state != IDLE);
   assign rsp_result = res_q;
   assign rsp_flags  = flags_q;
   assign rsp_tag    = op_tag;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_add_arbiter
//  Purpose  : Directed self-checking bench for fp_add_arbiter (CNT_W=2 so the
//             counter wrap is reachable). A table-driven stand-in returns
//             hand-computed sums for the operand pairs used here.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_arbiter;
   localparam int TAG_W = 4;
   localparam int CNT_W = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [1:0]         req_valid, req_ready, rsp_valid, rsp_ready, rsp_flags;
   logic [63:0]        req_a, req_b;
   logic [5:0]         req_rmode;
   logic [2*TAG_W-1:0] req_tag;
   logic [31:0]        rsp_result, add_a, add_b, add_result;
   logic [TAG_W-1:0]   rsp_tag;
   logic [2:0]         add_rmode;
   logic               add_overflow, add_underflow, busy;
   logic [CNT_W-1:0]   done_count;

   int passed = 0;
   int total  = 0;

   fp_add_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_rmode(req_rmode), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
      .add_a(add_a), .add_b(add_b), .add_rmode(add_rmode),
      .add_result(add_result), .add_overflow(add_overflow),
      .add_underflow(add_underflow),
      .busy(busy), .done_count(done_count)
   );

   always #5 clk = ~clk;

   // Shared adder stand-in: hand-computed IEEE-754 sums for the vectors used.
   always_comb begin
      add_result    = 32'h7FC00000;
      add_overflow  = 1'b0;
      add_underflow = 1'b0;
      case ({add_a, add_b})
         {32'h3F800000, 32'h3F800000}: add_result = 32'h40000000; // 1+1=2
         {32'h3F800000, 32'h40000000}: add_result = 32'h40400000; // 1+2=3
         {32'h40000000, 32'h40000000}: add_result = 32'h40800000; // 2+2=4
         {32'h7F7FFFFF, 32'h7F7FFFFF}: begin                       // max+max
            add_result   = 32'h7F800000;
            add_overflow = 1'b1;
         end
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
      req_a = '0; req_b = '0; req_rmode = '0; req_tag = '0;
      tick(); tick();
      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_rmode", add_rmode, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_flags", rsp_flags, 0);
      chk("rst_tag", rsp_tag, 0);
      chk("rst_done", done_count, 0);
      chk("rst_ready_none", req_ready, 2'b00);
      req_valid = 2'b01; #1;
      chk("rst_ready_req0", req_ready, 2'b01);
      req_valid = 2'b00; rst_n = 1'b1;
      tick();

      // Single operation: 1.0 + 1.0, tag 5
      req_a = {32'h0, 32'h3F800000}; req_b = {32'h0, 32'h3F800000};
      req_rmode = 6'b000000; req_tag = 8'h05; req_valid = 2'b01; #1;
      chk("single_ready", req_ready, 2'b01);
      tick(); req_valid = 2'b00; #1;                 // N+1: EXEC
      chk("single_busy", busy, 1);
      chk("single_add_a", add_a, 32'h3F800000);
      chk("single_add_b", add_b, 32'h3F800000);
      chk("single_exec_ready", req_ready, 2'b00);
      chk("single_exec_rsp", rsp_valid, 2'b00);
      tick();                                        // N+2: RESP
      chk("single_rsp_valid", rsp_valid, 2'b01);
      chk("single_result", rsp_result, 32'h40000000);
      chk("single_tag", rsp_tag, 4'h5);
      chk("single_flags", rsp_flags, 2'b00);
      tick();
      chk("single_idle_rsp", rsp_valid, 2'b00);
      chk("single_idle_busy", busy, 0);
      chk("single_done", done_count, 1);

      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("rerst_done", done_count, 0);

      // Tie after reset: req0 (1+2, tag 1), req1 (2+2, tag 2, rmode 111)
      req_a = {32'h40000000, 32'h3F800000}; req_b = {32'h40000000, 32'h40000000};
      req_rmode = {3'b111, 3'b000}; req_tag = {4'h2, 4'h1}; req_valid = 2'b11; #1;
      chk("tie_ready", req_ready, 2'b01);
      tick(); req_valid = 2'b10; #1;
      chk("tie_exec_a", add_a, 32'h3F800000);
      chk("tie_exec_b", add_b, 32'h40000000);
      chk("tie_exec_ready", req_ready, 2'b00);
      tick();
      chk("tie_rsp_valid", rsp_valid, 2'b01);
      chk("tie_result", rsp_result, 32'h40400000);
      chk("tie_tag", rsp_tag, 4'h1);
      chk("tie_rsp_ready", req_ready, 2'b00);
      tick();
      chk("tie_done1", done_count, 1);
      chk("tie_req1_ready", req_ready, 2'b10);
      tick(); req_valid = 2'b00; #1;
      chk("rmode_coerce", add_rmode, 3'b000);
      chk("req1_add_a", add_a, 32'h40000000);
      tick();
      chk("req1_rsp_valid", rsp_valid, 2'b10);
      chk("req1_result", rsp_result, 32'h40800000);
      chk("req1_tag", rsp_tag, 4'h2);
      rsp_ready = 2'b01;                            // wrong port: ignored
      tick();
      chk("ignore_rsp_valid", rsp_valid, 2'b10);
      chk("ignore_busy", busy, 1);
      chk("ignore_done", done_count, 1);
      rsp_ready = 2'b10;
      tick();
      chk("req1_idle", busy, 0);
      chk("req1_done", done_count, 2);

      // Alternation + backpressure: req0 (1+1, tag 7), req1 (max+max, tag 9)
      req_a = {32'h7F7FFFFF, 32'h3F800000}; req_b = {32'h7F7FFFFF, 32'h3F800000};
      req_rmode = {3'b000, 3'b001}; req_tag = {4'h9, 4'h7}; req_valid = 2'b11; #1;
      chk("alt_ready", req_ready, 2'b01);
      rsp_ready = 2'b00;
      tick(); req_valid = 2'b10; #1;
      chk("alt_exec_rmode", add_rmode, 3'b001);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", rsp_valid, 2'b01);
         chk("bp_result", rsp_result, 32'h40000000);
         chk("bp_tag", rsp_tag, 4'h7);
         chk("bp_req_ready", req_ready, 2'b00);
         chk("bp_busy", busy, 1);
         tick();
      end
      rsp_ready = 2'b01; #1;
      chk("bp_last_valid", rsp_valid, 2'b01);
      tick();
      chk("bp_idle", busy, 0);
      chk("bp_done", done_count, 3);
      chk("bp_req1_ready", req_ready, 2'b10);
      tick(); req_valid = 2'b00; tick();
      chk("ovf_rsp_valid", rsp_valid, 2'b10);
      chk("ovf_result", rsp_result, 32'h7F800000);
      chk("ovf_flags", rsp_flags, 2'b10);
      chk("ovf_tag", rsp_tag, 4'h9);
      rsp_ready = 2'b11;
      tick();
      chk("wrap_done", done_count, 0);

      // Reset during RESP discards the operation
      req_a = {32'h0, 32'h3F800000}; req_b = {32'h0, 32'h3F800000};
      req_rmode = 6'b000000; req_tag = 8'h03; req_valid = 2'b01;
      tick(); req_valid = 2'b00; tick();
      chk("midrst_pre_valid", rsp_valid, 2'b01);
      rst_n = 1'b0;
      tick();
      chk("midrst_rsp_valid", rsp_valid, 2'b00);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done_count, 0);
      chk("midrst_result", rsp_result, 0);
      chk("midrst_tag", rsp_tag, 0);
      chk("midrst_add_a", add_a, 0);
      rst_n = 1'b1;
      tick(); tick();
      chk("midrst_no_rsp", rsp_valid, 2'b00);
      chk("midrst_no_done", done_count, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire
